// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet deframer.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        DISC = 3'd3,
        CHK  = 3'd4,
        HOLD = 3'd5
    } state_e;

    // Command codes of the image-control protocol; the deframer passes every
    // code through untouched, these are here for the consumer side.
    localparam logic [7:0] CMD_SETIMG = 8'h53;
    localparam logic [7:0] CMD_GETIMG = 8'h43;

    // One accumulator step: modulo-256 add or bytewise xor.
    function automatic logic [7:0] chk_step(input logic [7:0] acc,
                                            input logic [7:0] data,
                                            input logic       xor_mode);
        return xor_mode ? (acc ^ data) : (acc + data);
    endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Payload buffer: simple dual-port NUMBER x 8, synchronous write, registered read.
module pkt_buf_ram #(
    parameter  int NUMBER = 256,
    localparam int AW     = $clog2(NUMBER)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [NUMBER];
    logic [7:0] rd_q;

    // Write port plus registered read port (read output cleared by reset).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/uart_pkt_deframer.sv
// Frames {cmd, len, data[len], chk} packets from a UART byte stream, checks the
// checksum, buffers the payload and offers good packets with valid/ready.
module uart_pkt_deframer
    import uart_pkt_pkg::*;
#(
    parameter  int    CLOCK      = 50_000_000,
    parameter  int    BAUD       = 115_200,
    parameter  int    NUMBER     = 256,
    parameter  int    RX_TIMEOUT = 2,
    parameter  string CHK_MODE   = "SUM",
    localparam int    AW         = $clog2(NUMBER)
) (
    input  logic          inclk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          pkt_valid,
    input  logic          pkt_ready,
    output logic [7:0]    pkt_cmd,
    output logic [8:0]    pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_tmo,
    output logic          err_drop,
    output logic          busy
);

    localparam int          BYTE_CYC = 10 * (CLOCK / BAUD);
    localparam int          TO_CYC   = RX_TIMEOUT * BYTE_CYC;
    localparam int          TW       = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TO_CYC - 1);
    localparam logic [8:0]  NUM9     = 9'(NUMBER);
    localparam logic        XOR_MODE = (CHK_MODE == "XOR");

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [8:0]    len_q, len_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [7:0]    acc_q, acc_d;
    logic          over_q, over_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    pkt_cmd_q, pkt_cmd_d;
    logic [8:0]    pkt_len_q, pkt_len_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_drop_q, err_drop_d;
    logic          we;
    logic [8:0]    eff_len;
    logic [7:0]    exp_chk;
    logic          in_pkt;

    // Next-state logic: framing FSM, byte counter, checksum and inter-byte timer.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        over_d     = over_q;
        pkt_cmd_d  = pkt_cmd_q;
        pkt_len_d  = pkt_len_q;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        err_drop_d = 1'b0;
        we         = 1'b0;
        // A length byte of zero means a full 256-byte payload.
        eff_len    = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        exp_chk    = ~acc_q;
        in_pkt     = (state_q != IDLE) && (state_q != HOLD);
        timer_d    = (!in_pkt || rx_valid) ? '0 : timer_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    acc_d   = rx_data;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    len_d   = eff_len;
                    cnt_d   = '0;
                    acc_d   = chk_step(acc_q, rx_data, XOR_MODE);
                    over_d  = (eff_len > NUM9);
                    state_d = (eff_len > NUM9) ? DISC : DATA;
                end
            end
            DATA, DISC: begin
                if (rx_valid) begin
                    // Oversize payloads are only counted so the buffer keeps the last good packet.
                    we    = (state_q == DATA);
                    acc_d = chk_step(acc_q, rx_data, XOR_MODE);
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q + 9'd1 == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (over_q) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else if (rx_data != exp_chk) begin
                        err_chk_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        pkt_cmd_d = cmd_q;
                        pkt_len_d = len_q;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (rx_valid && pkt_ready) begin
                    // Consumer takes the packet and the same byte opens the next one.
                    cmd_d   = rx_data;
                    acc_d   = rx_data;
                    state_d = LEN;
                end else if (rx_valid) begin
                    err_drop_d = 1'b1;
                end else if (pkt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte arriving in the terminal cycle takes priority over the timeout.
        if (in_pkt && !rx_valid && (timer_q == TMO_LAST)) begin
            state_d   = IDLE;
            err_tmo_d = 1'b1;
            timer_d   = '0;
        end
    end

    // State registers, all cleared by reset so a partial packet is discarded.
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            over_q     <= 1'b0;
            timer_q    <= '0;
            pkt_cmd_q  <= '0;
            pkt_len_q  <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            over_q     <= over_d;
            timer_q    <= timer_d;
            pkt_cmd_q  <= pkt_cmd_d;
            pkt_len_q  <= pkt_len_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            err_drop_q <= err_drop_d;
        end
    end

    pkt_buf_ram #(.NUMBER(NUMBER)) u_buf (
        .clk     (inclk),
        .rst     (reset),
        .we      (we),
        .wr_addr (cnt_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign pkt_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign pkt_cmd   = pkt_cmd_q;
    assign pkt_len   = pkt_len_q;
    assign err_chk   = err_chk_q;
    assign err_len   = err_len_q;
    assign err_tmo   = err_tmo_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed bench for uart_pkt_deframer: default, NUMBER=4 and XOR-checksum instances.
module tb_uart_pkt_deframer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pkt_ready;
    logic [7:0] rd_addr;
    int         tgt;
    int         n_checks = 0;
    int         n_errors = 0;

    logic rxv_m, rxv_4, rxv_x;
    assign rxv_m = rx_valid && (tgt == 0);
    assign rxv_4 = rx_valid && (tgt == 1);
    assign rxv_x = rx_valid && (tgt == 2);

    logic       v_m, e_chk_m, e_len_m, e_tmo_m, e_drop_m, busy_m;
    logic [7:0] cmd_m, rd_m;
    logic [8:0] len_m;
    logic       v_4, e_chk_4, e_len_4, e_tmo_4, e_drop_4, busy_4;
    logic [7:0] cmd_4, rd_4;
    logic [8:0] len_4;
    logic       v_x, e_chk_x, e_len_x, e_tmo_x, e_drop_x, busy_x;
    logic [7:0] cmd_x, rd_x;
    logic [8:0] len_x;

    uart_pkt_deframer dut (
        .inclk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rxv_m),
        .pkt_valid(v_m), .pkt_ready(pkt_ready), .pkt_cmd(cmd_m), .pkt_len(len_m),
        .rd_addr(rd_addr), .rd_data(rd_m), .err_chk(e_chk_m), .err_len(e_len_m),
        .err_tmo(e_tmo_m), .err_drop(e_drop_m), .busy(busy_m)
    );

    uart_pkt_deframer #(.NUMBER(4)) dut4 (
        .inclk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rxv_4),
        .pkt_valid(v_4), .pkt_ready(pkt_ready), .pkt_cmd(cmd_4), .pkt_len(len_4),
        .rd_addr(rd_addr[1:0]), .rd_data(rd_4), .err_chk(e_chk_4), .err_len(e_len_4),
        .err_tmo(e_tmo_4), .err_drop(e_drop_4), .busy(busy_4)
    );

    uart_pkt_deframer #(.CHK_MODE("XOR")) dutx (
        .inclk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rxv_x),
        .pkt_valid(v_x), .pkt_ready(pkt_ready), .pkt_cmd(cmd_x), .pkt_len(len_x),
        .rd_addr(rd_addr), .rd_data(rd_x), .err_chk(e_chk_x), .err_len(e_len_x),
        .err_tmo(e_tmo_x), .err_drop(e_drop_x), .busy(busy_x)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int t, input logic [7:0] b);
        tgt      = t;
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pay [256];
    logic [7:0] acc;
    int         cyc;

    initial begin
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; pkt_ready = 1'b0;
        rd_addr = '0; tgt = 0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", v_m, 0);
        check("rst_busy", {busy_m, busy_4, busy_x}, 0);
        check("rst_errs", {e_chk_m, e_len_m, e_tmo_m, e_drop_m}, 0);
        check("rst_cmd_len", {cmd_m, len_m}, 0);
        check("rst_rd", rd_m, 0);
        reset = 1'b0;
        tick();

        // 1: SETIMG 53 01 03 A8
        send(0, 8'h53);
        check("t1_busy", busy_m, 1);
        send(0, 8'h01); send(0, 8'h03); send(0, 8'hA8);
        check("t1_valid", v_m, 1);
        check("t1_cmd", cmd_m, 8'h53);
        check("t1_len", len_m, 9'd1);
        check("t1_noerr", {e_chk_m, e_len_m, e_tmo_m, e_drop_m}, 0);
        rd_addr = 8'd0; tick();
        check("t1_rd0", rd_m, 8'h03);
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
        check("t1_release", {v_m, busy_m}, 0);

        // 2: GETIMG 43 01 00 BB, ready held low 50 cycles
        send(0, 8'h43); send(0, 8'h01); send(0, 8'h00); send(0, 8'hBB);
        check("t2_valid", v_m, 1);
        repeat (50) tick();
        check("t2_hold_valid", v_m, 1);
        check("t2_cmd", cmd_m, 8'h43);
        // byte without ready is dropped, packet stays held
        send(0, 8'h77);
        check("t2_drop", e_drop_m, 1);
        check("t2_drop_valid", v_m, 1);
        tick();
        check("t2_drop_pulse", e_drop_m, 0);
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
        check("t2_release", v_m, 0);

        // 3: bad checksum, then a good packet
        send(0, 8'h53); send(0, 8'h01); send(0, 8'h03); send(0, 8'hA9);
        check("t3_errchk", e_chk_m, 1);
        check("t3_valid", {v_m, busy_m}, 0);
        tick();
        check("t3_pulse", e_chk_m, 0);
        send(0, 8'h53); send(0, 8'h01); send(0, 8'h03); send(0, 8'hA8);
        check("t3_good", v_m, 1);
        // next cmd accepted in the same cycle as ready
        pkt_ready = 1'b1; send(0, 8'h43); pkt_ready = 1'b0;
        check("t3_b2b", {v_m, busy_m, e_drop_m}, 3'b010);
        send(0, 8'h01); send(0, 8'h00); send(0, 8'hBB);
        check("t3_b2b_pkt", {v_m, cmd_m}, {1'b1, 8'h43});
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;

        // 4: NUMBER=4, good packet then oversize packet
        send(1, 8'h10); send(1, 8'h02); send(1, 8'hAA); send(1, 8'hBB); send(1, 8'h88);
        check("t4_good", {v_4, len_4}, {1'b1, 9'd2});
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
        send(1, 8'h74); send(1, 8'h05);
        send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44); send(1, 8'h55);
        check("t4_busy", busy_4, 1);
        send(1, 8'h87);
        check("t4_errlen", {e_len_4, e_chk_4}, 2'b10);
        check("t4_idle", {v_4, busy_4}, 0);
        rd_addr = 8'd0; tick();
        check("t4_rd0", rd_4, 8'hAA);
        rd_addr = 8'd1; tick();
        check("t4_rd1", rd_4, 8'hBB);

        // 5: len 00 -> 256 bytes
        acc = 8'h53 + 8'h00;
        send(0, 8'h53); send(0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            pay[i] = 8'($urandom_range(0, 255));
            acc = acc + pay[i];
            send(0, pay[i]);
        end
        send(0, ~acc);
        check("t5_valid", v_m, 1);
        check("t5_len", len_m, 9'd256);
        for (int i = 0; i < 256; i++) begin
            rd_addr = 8'(i); tick();
            check("t5_rd", rd_m, pay[i]);
        end
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;

        // 6a: timeout after 8680 idle cycles
        send(0, 8'h53); send(0, 8'h01);
        cyc = 0;
        for (int i = 1; i <= 9000; i++) begin
            tick();
            if (e_tmo_m) begin
                cyc = i;
                break;
            end
        end
        check("t6_tmo_cycle", cyc, 8680);
        check("t6_tmo_idle", busy_m, 0);
        // 6b: byte in the terminal cycle wins over the timeout
        send(0, 8'h53); send(0, 8'h01);
        repeat (8679) tick();
        send(0, 8'h03);
        check("t6_edge_notmo", {e_tmo_m, busy_m}, 2'b01);
        send(0, 8'hA8);
        check("t6_edge_pkt", v_m, 1);
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
        // 6c: reset mid-DATA
        send(0, 8'h53); send(0, 8'h03); send(0, 8'hAA);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_busy", busy_m, 0);
        send(0, 8'h53); send(0, 8'h01); send(0, 8'h03); send(0, 8'hA8);
        check("t6_after_rst", {v_m, e_chk_m}, 2'b10);
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;

        // 7: XOR checksum mode
        send(2, 8'h53); send(2, 8'h01); send(2, 8'h03); send(2, 8'hAE);
        check("t7_xor_good", {v_x, e_chk_x}, 2'b10);
        pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
        send(2, 8'h53); send(2, 8'h01); send(2, 8'h03); send(2, 8'hA8);
        check("t7_xor_bad", {v_x, e_chk_x}, 2'b01);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
